// File: rtl/cnn_conv_sequencer.sv
// cnn_conv_sequencer: address/control sequencer for the vector MAC datapath.
// Walks a valid 2-D convolution (output row, output col, filter row, chunk)
// and emits one VECTOR_SIZE-wide read beat per accepted handshake.
// Optional feature macro: CNN_SEQ_PERF_EN adds beat and stall counters.
module cnn_conv_sequencer #(
  parameter int VECTOR_SIZE = 8,
  parameter int DIM_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                   clkIn,
  input  logic                   rstIn,
  input  logic                   startIn,
  input  logic [DIM_WIDTH-1:0]   filtRowsIn,
  input  logic [DIM_WIDTH-1:0]   filtColsIn,
  input  logic [DIM_WIDTH-1:0]   dataRowsIn,
  input  logic [DIM_WIDTH-1:0]   dataColsIn,
  input  logic                   readyIn,
  output logic                   validOut,
  output logic [ADDR_WIDTH-1:0]  dataAddrOut,
  output logic [ADDR_WIDTH-1:0]  filtAddrOut,
  output logic [VECTOR_SIZE-1:0] laneMaskOut,
  output logic                   lastOut,
  output logic                   busyOut,
  output logic                   doneOut,
  output logic                   errOut
`ifdef CNN_SEQ_PERF_EN
  ,
  output logic [31:0]            stallCntOut,
  output logic [31:0]            beatCntOut
`endif
);

  localparam int LANE_SHIFT = $clog2(VECTOR_SIZE);
  localparam logic [DIM_WIDTH-1:0]   LANE_MOD  = DIM_WIDTH'(VECTOR_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]  VEC_STEP  = ADDR_WIDTH'(VECTOR_SIZE);
  localparam logic [2*DIM_WIDTH-1:0] MAX_ELEMS = (2*DIM_WIDTH)'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} stateT;
  stateT state;

  logic [DIM_WIDTH-1:0]   filtRows, filtCols, dataRows, dataCols;
  logic [DIM_WIDTH-1:0]   outRows, outCols, chunks;
  logic [VECTOR_SIZE-1:0] lastMask;
  logic [DIM_WIDTH-1:0]   rIdx, cIdx, frIdx, kIdx;
  logic [ADDR_WIDTH-1:0]  rowStart, cellBase, rowAddr, filtRowAddr;

  // Setup-phase derived quantities (from latched dimensions)
  logic [DIM_WIDTH-1:0]   rem, setupChunks;
  logic [VECTOR_SIZE-1:0] setupLastMask;
  logic [2*DIM_WIDTH-1:0] dataElems;
  logic                   setupErr;

  // Next-beat values for the incremental loop nest
  logic [DIM_WIDTH-1:0]   nextK, nextFr, nextC, nextR;
  logic [ADDR_WIDTH-1:0]  nextRowStart, nextCellBase, nextRowAddr, nextDataAddr;
  logic [ADDR_WIDTH-1:0]  nextFiltRowAddr, nextFiltAddr;
  logic                   nextKLast, nextFrLast, finalBeat;
  logic                   kLast, frLast, cLast, rLast;
  logic [ADDR_WIDTH-1:0]  colStep, filtStep;
  logic                   accept;

  assign colStep  = ADDR_WIDTH'(dataCols);
  assign filtStep = ADDR_WIDTH'(filtCols);
  assign kLast    = (kIdx  == chunks   - 1'b1);
  assign frLast   = (frIdx == filtRows - 1'b1);
  assign cLast    = (cIdx  == outCols  - 1'b1);
  assign rLast    = (rIdx  == outRows  - 1'b1);
  assign accept   = validOut && readyIn;

  // Chunk count, final-chunk lane mask and configuration check
  always_comb begin
    rem           = filtCols & LANE_MOD;
    setupChunks   = (filtCols >> LANE_SHIFT) + DIM_WIDTH'(rem != '0);
    setupLastMask = (rem == '0) ? '1 : ~({VECTOR_SIZE{1'b1}} << rem);
    dataElems     = (2*DIM_WIDTH)'(dataRows) * (2*DIM_WIDTH)'(dataCols);
    setupErr      = (filtRows == '0) || (filtCols == '0) ||
                    (dataRows == '0) || (dataCols == '0) ||
                    (filtRows > dataRows) || (filtCols > dataCols) ||
                    (dataElems > MAX_ELEMS);
  end

  // Advance chunk, then filter row, then output col, then output row
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    nextK           = kIdx;
    nextFr          = frIdx;
    nextC           = cIdx;
    nextR           = rIdx;
    nextRowStart    = rowStart;
    nextCellBase    = cellBase;
    nextRowAddr     = rowAddr;
    nextDataAddr    = dataAddrOut;
    nextFiltRowAddr = filtRowAddr;
    nextFiltAddr    = filtAddrOut;
    nextKLast       = kLast;
    nextFrLast      = frLast;
    finalBeat       = 1'b0;
    if (!kLast) begin
      nextK        = kIdx + 1'b1;
      nextDataAddr = dataAddrOut + VEC_STEP;
      nextFiltAddr = filtAddrOut + VEC_STEP;
      nextKLast    = (kIdx + 1'b1 == chunks - 1'b1);
    end else begin
      nextK     = '0;
      nextKLast = (chunks == DIM_WIDTH'(1));
      if (!frLast) begin
        nextFr          = frIdx + 1'b1;
        nextRowAddr     = rowAddr + colStep;
        nextDataAddr    = rowAddr + colStep;
        nextFiltRowAddr = filtRowAddr + filtStep;
        nextFiltAddr    = filtRowAddr + filtStep;
        nextFrLast      = (frIdx + 1'b1 == filtRows - 1'b1);
      end else begin
        nextFr          = '0;
        nextFiltRowAddr = '0;
        nextFiltAddr    = '0;
        nextFrLast      = (filtRows == DIM_WIDTH'(1));
        if (!cLast) begin
          nextC        = cIdx + 1'b1;
          nextCellBase = cellBase + 1'b1;
          nextRowAddr  = cellBase + 1'b1;
          nextDataAddr = cellBase + 1'b1;
        end else begin
          nextC = '0;
          if (!rLast) begin
            nextR        = rIdx + 1'b1;
            nextRowStart = rowStart + colStep;
            nextCellBase = rowStart + colStep;
            nextRowAddr  = rowStart + colStep;
            nextDataAddr = rowStart + colStep;
          end else begin
            finalBeat = 1'b1;
          end
        end
      end
    end
  end

  // Control FSM with registered beat and status outputs
  always_ff @(posedge clkIn or negedge rstIn) begin
    // NOTE: every register, including the latched configuration, is reset so a mid-run reset leaves no partial beat.
    if (!rstIn) begin
      state       <= IDLE;
      filtRows    <= '0;
      filtCols    <= '0;
      dataRows    <= '0;
      dataCols    <= '0;
      outRows     <= '0;
      outCols     <= '0;
      chunks      <= '0;
      lastMask    <= '0;
      rIdx        <= '0;
      cIdx        <= '0;
      frIdx       <= '0;
      kIdx        <= '0;
      rowStart    <= '0;
      cellBase    <= '0;
      rowAddr     <= '0;
      filtRowAddr <= '0;
      validOut    <= 1'b0;
      dataAddrOut <= '0;
      filtAddrOut <= '0;
      laneMaskOut <= '0;
      lastOut     <= 1'b0;
      busyOut     <= 1'b0;
      doneOut     <= 1'b0;
      errOut      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (startIn) begin
            filtRows <= filtRowsIn;
            filtCols <= filtColsIn;
            dataRows <= dataRowsIn;
            dataCols <= dataColsIn;
            errOut   <= 1'b0;
            busyOut  <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          outRows     <= dataRows - filtRows + 1'b1;
          outCols     <= dataCols - filtCols + 1'b1;
          chunks      <= setupChunks;
          lastMask    <= setupLastMask;
          rIdx        <= '0;
          cIdx        <= '0;
          frIdx       <= '0;
          kIdx        <= '0;
          rowStart    <= '0;
          cellBase    <= '0;
          rowAddr     <= '0;
          filtRowAddr <= '0;
          dataAddrOut <= '0;
          filtAddrOut <= '0;
          if (setupErr) begin
            errOut  <= 1'b1;
            doneOut <= 1'b1;
            state   <= DONE;
          end else begin
            validOut    <= 1'b1;
            laneMaskOut <= (setupChunks == DIM_WIDTH'(1)) ? setupLastMask : '1;
            lastOut     <= (filtRows == DIM_WIDTH'(1)) && (setupChunks == DIM_WIDTH'(1));
            state       <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (finalBeat) begin
              validOut    <= 1'b0;
              dataAddrOut <= '0;
              filtAddrOut <= '0;
              laneMaskOut <= '0;
              lastOut     <= 1'b0;
              doneOut     <= 1'b1;
              state       <= DONE;
            end else begin
              kIdx        <= nextK;
              frIdx       <= nextFr;
              cIdx        <= nextC;
              rIdx        <= nextR;
              rowStart    <= nextRowStart;
              cellBase    <= nextCellBase;
              rowAddr     <= nextRowAddr;
              filtRowAddr <= nextFiltRowAddr;
              dataAddrOut <= nextDataAddr;
              filtAddrOut <= nextFiltAddr;
              laneMaskOut <= nextKLast ? lastMask : '1;
              lastOut     <= nextKLast && nextFrLast;
            end
          end
        end
        DONE: begin
          doneOut <= 1'b0;
          busyOut <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CNN_SEQ_PERF_EN
  // Saturating accepted-beat and stall-cycle counters, cleared on start
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      beatCntOut  <= '0;
      stallCntOut <= '0;
    end else if (state == IDLE && startIn) begin
      beatCntOut  <= '0;
      stallCntOut <= '0;
    end else if (state == RUN) begin
      if (accept && beatCntOut != '1)
        beatCntOut <= beatCntOut + 1'b1;
      if (validOut && !readyIn && stallCntOut != '1)
        stallCntOut <= stallCntOut + 1'b1;
    end
  end
`endif

endmodule

// File: doc/cnn_conv_sequencer.md
# cnn_conv_sequencer

Address and control sequencer for the CNN accelerator's vector multiply-and-accumulate datapath. On start it walks a "valid" 2-D convolution of a row-major filter over a row-major data matrix. Each beat is one VECTOR_SIZE-wide read request: data element address, filter element address, lane mask and an end-of-cell flag. The downstream RAM-read/rotate stage consumes these beats and feeds the MAC, whose output FIFO backpressures through readyIn.

## Interface
- VECTOR_SIZE, 8: lanes per beat; power of two.
- DIM_WIDTH, 16: width of each dimension input.
- ADDR_WIDTH, 12: element address width; the data matrix may hold at most 2^ADDR_WIDTH elements.

- clkIn  input  1  clock.
- rstIn  input  1  reset; asynchronous, active-low.
- startIn  input  1  start pulse; sampled only in IDLE.
- filtRowsIn / filtColsIn  input  DIM_WIDTH each  filter dimensions.
- dataRowsIn / dataColsIn  input  DIM_WIDTH each  data dimensions.
- readyIn  input  1  downstream accepts the beat.
- validOut  output  1  beat valid.
- dataAddrOut  output  ADDR_WIDTH  element index of lane 0 in the data matrix.
- filtAddrOut  output  ADDR_WIDTH  element index of lane 0 in the filter.
- laneMaskOut  output  VECTOR_SIZE  active lanes; bit i is lane i.
- lastOut  output  1  final beat of the current output cell.
- busyOut  output  1  not IDLE.
- doneOut  output  1  one-cycle completion pulse.
- errOut  output  1  last start had an invalid configuration; held until the next start.
- stallCntOut / beatCntOut  output  32 each  present only with CNN_SEQ_PERF_EN.

## Operation
- States: IDLE, SETUP, RUN, DONE.
- IDLE -> SETUP on startIn.
  - Latch all dimensions.
  - Clear errOut and the perf counters.
- SETUP (1 cycle):
  - Compute outRows = dataRows-filtRows+1, outCols = dataCols-filtCols+1, chunks = ceil(filtCols/VECTOR_SIZE), lastMask = lanes in the final chunk.
  - Error if any dimension is 0, filtRows>dataRows, filtCols>dataCols, or dataRows*dataCols>2^ADDR_WIDTH.
  - On error: set errOut and go to DONE. Otherwise go to RUN.
- RUN: loop nest, outermost first: output row r, output col c, filter row fr, chunk k. Per beat:
  - dataAddr = (r+fr)*dataCols + c + k*VECTOR_SIZE.
  - filtAddr = fr*filtCols + k*VECTOR_SIZE.
  - mask = all ones, or lastMask when k = chunks-1.
  - last = (fr = filtRows-1) and (k = chunks-1).
  - Addresses are maintained incrementally by adders; no per-beat multiplier. The SETUP error check may use one multiplier.
- The loop nest advances only on validOut & readyIn.
- Acceptance of the beat with r, c, fr and k all at their maxima -> DONE.
- DONE (1 cycle): doneOut=1, then IDLE.
- startIn outside IDLE is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH. A valid configuration never wraps.

## Timing
- Reset: asynchronous, takes effect immediately. All outputs go to 0 and state to IDLE, including mid-RUN. No partial beat survives.
- Latency:
  - startIn at cycle 0 -> SETUP at cycle 1 -> first validOut at cycle 2.
  - On error, doneOut at cycle 2 and validOut never asserts.
- Handshake:
  - While validOut & !readyIn, every beat output holds stable.
  - validOut never drops without acceptance.
  - With readyIn held high: one beat per cycle, no bubbles, including across cell boundaries.
- Completion: doneOut asserts the cycle after the final beat is accepted. validOut is 0 that cycle.
- busyOut is 1 in SETUP, RUN and DONE.

## Configuration
- CNN_SEQ_PERF_EN defined:
  - beatCntOut counts accepted beats.
  - stallCntOut counts cycles with validOut & !readyIn.
  - Both clear on start, saturate at 2^32-1, and hold after DONE.
- Undefined: both ports and their counters are absent.

## Test plan
- Filter 3x3, data 4x4, VECTOR_SIZE=8, readyIn=1 -> 12 beats, all mask 0x07.
  - Cell (0,0): dataAddr 0/4/8, filtAddr 0/3/6; lastOut on the third beat.
  - Cell (0,1) starts at dataAddr 1; cell (1,0) at dataAddr 4.
  - doneOut on cycle 14.
- Filter 1x10, data 2x12 -> 6 cells, 12 beats.
  - Cell (0,0): (dataAddr 0, filtAddr 0, mask 0xFF), then (8, 8, 0x03, lastOut=1).
  - Cell (1,2) first beat dataAddr 14.
- Filter 3x3, data 4x4, readyIn low 5 cycles while beat 2 is presented -> beat 2 outputs unchanged through the stall; 12 beats total. With the macro: stallCntOut=5, beatCntOut=12.
- filtRows 5, dataRows 4 (and separately filtCols 0) -> errOut=1, doneOut on cycle 2, validOut never 1.
- rstIn low during beat 4 of the 3x3/4x4 run -> all outputs 0 immediately. After release and a new start, the first beat is dataAddr 0, filtAddr 0.
- Filter 1x1, data 1x1 -> exactly one beat: dataAddr 0, mask 0x01, lastOut=1. A startIn pulse during RUN of the 3x3 case has no effect on the 12-beat sequence.
